irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter_if.sv | 19 +
 rtl/irq_arbiter.sv | 162 ++++++++++++++++
 tb/tb_irq_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_if.sv
// Memory-mapped register bus between a CPU-side master and the interrupt arbiter.
interface irq_arbiter_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/irq_arbiter.sv
// Three-source interrupt arbiter: synchronizes irq_5..7, latches pending requests,
// dispatches one source at a time to the CPU and waits for its EOI or a timeout.
module irq_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] irq_in,
    input  logic [2:0] eoi,
    output logic [2:0] cpu_irq,
    irq_arbiter_if.slave bus
);
    localparam int unsigned NSRC  = 3;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, WAIT_EOI} state_e;

    state_e            state_q, state_d;
    logic [NSRC-1:0]   sync1_q, sync2_q, dly_q;
    logic [NSRC-1:0]   enable_q, enable_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   mode_q, mode_d;
    logic [NSRC-1:0]   overrun_q, overrun_d;
    logic              tmo_q, tmo_d;
    logic [NSRC-1:0]   active_q, active_d;
    logic [NSRC-1:0]   cpu_irq_q, cpu_irq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [NSRC-1:0]   rise_c, pend_en_c, pick_c, w1c_c, eoi_clr_c;
    logic              in_win_c, acc_c, wr0_c, wr1_c;
    logic [1:0]        off_c;
    logic [31:0]       rd_c;
    logic              unused_bits;

    assign unused_bits = ^{bus.iomem_addr[1:0], bus.iomem_wdata[31:9],
                           bus.iomem_wdata[7], bus.iomem_wdata[3], bus.iomem_wstrb[3:2]};

    // Two-flop synchronizer plus delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise_c    = sync2_q & ~dly_q;
    assign pend_en_c = pending_q & enable_q;
    assign pick_c    = pend_en_c[2] ? 3'b100 : (pend_en_c[1] ? 3'b010 : 3'b001);

    assign in_win_c = (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign acc_c    = bus.iomem_valid & in_win_c & ~ready_q;
    assign wr0_c    = acc_c & bus.iomem_wstrb[0];
    assign wr1_c    = acc_c & bus.iomem_wstrb[1];
    assign off_c    = bus.iomem_addr[3:2];
    assign w1c_c    = (wr0_c && off_c == 2'd1) ? bus.iomem_wdata[2:0] : 3'b000;

    always_comb begin
        rd_c = '0;
        case (off_c)
            2'd0:    rd_c = {29'd0, enable_q};
            2'd1:    rd_c = {29'd0, pending_q};
            2'd2:    rd_c = {29'd0, mode_q};
            default: rd_c = {23'd0, tmo_q, 1'b0, overrun_q, 1'b0, active_q};
        endcase
    end

    // Next-state: dispatch FSM, register file and bus response
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        cpu_irq_d = '0;
        cnt_d     = cnt_q;
        enable_d  = enable_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        tmo_d     = tmo_q;
        eoi_clr_c = '0;
        ready_d   = acc_c;
        rdata_d   = acc_c ? rd_c : 32'd0;

        case (state_q)
            IDLE: begin
                if (|pend_en_c) begin
                    state_d   = WAIT_EOI;
                    active_d  = pick_c;
                    cpu_irq_d = pick_c;
                    cnt_d     = '0;
                end
            end
            WAIT_EOI: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (|(eoi & active_q)) begin
                    eoi_clr_c = active_q;
                    active_d  = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_d    = 1'b1;
                    active_d = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr0_c && off_c == 2'd0) enable_d = bus.iomem_wdata[2:0];
        if (wr0_c && off_c == 2'd2) mode_d   = bus.iomem_wdata[2:0];
        if (wr0_c && off_c == 2'd3) overrun_d = overrun_q & ~bus.iomem_wdata[6:4];
        if (wr1_c && off_c == 2'd3 && bus.iomem_wdata[8] && !(tmo_d && !tmo_q)) tmo_d = 1'b0;
        overrun_d = overrun_d | (rise_c & pending_q & mode_q);

        // Edge sources latch and clear; level sources simply follow the synchronized input
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i])
                pending_d[i] = rise_c[i] | (pending_q[i] & ~(w1c_c[i] | eoi_clr_c[i]));
            else
                pending_d[i] = sync2_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            active_q  <= '0;
            cpu_irq_q <= '0;
            cnt_q     <= '0;
            enable_q  <= '0;
            mode_q    <= 3'b111;
            pending_q <= '0;
            overrun_q <= '0;
            tmo_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            cpu_irq_q <= cpu_irq_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            tmo_q     <= tmo_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cpu_irq         = cpu_irq_q;
    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: dispatch latency, priority, overrun, timeout,
// level mode, reset behaviour and bus window decoding.
module tb_irq_arbiter;
    localparam logic [31:0] BASE   = 32'h0300_0000;
    localparam logic [31:0] A_EN   = BASE + 32'h0;
    localparam logic [31:0] A_PEND = BASE + 32'h4;
    localparam logic [31:0] A_MODE = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] irq_in;
    logic [2:0] eoi;
    logic [2:0] cpu_irq;
    int         n_pass = 0;
    int         n_total = 0;

    irq_arbiter_if bus ();

    irq_arbiter #(.BASE_ADDR(BASE), .TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .eoi     (eoi),
        .cpu_irq (cpu_irq),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                              output logic [31:0] r, output logic ok);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wstrb = s;
        bus.iomem_wdata = d;
        ok = 1'b0;
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            if (!ok) begin
                tick();
                if (bus.iomem_ready === 1'b1) begin
                    ok = 1'b1;
                    r  = bus.iomem_rdata;
                end
            end
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick();
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        logic        ok;
        bus_access(a, s, d, r, ok);
        chk({tag, "_ready"}, 32'(ok), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        ok;
        bus_access(a, 4'h0, 32'd0, r, ok);
        chk({tag, "_ready"}, 32'(ok), 32'd1);
        chk(tag, r, exp);
    endtask

    task automatic wait_dispatch(output logic [2:0] got, output int n);
        got = '0;
        n   = 0;
        while (got == 3'b000 && n < 40) begin
            tick();
            n++;
            got = cpu_irq;
        end
    endtask

    task automatic eoi_pulse(input logic [2:0] v);
        eoi = v;
        tick();
        eoi = 3'b000;
    endtask

    logic [2:0] got;
    int         n;
    logic [2:0] sched [8];
    logic [31:0] r_oob;
    logic        ok_oob;

    initial begin
        reset = 1'b1;
        irq_in = '0;
        eoi = '0;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = '0;
        bus.iomem_addr  = '0;
        bus.iomem_wdata = '0;
        repeat (3) tick();
        chk("rst_cpu_irq", 32'(cpu_irq), 32'd0);
        chk("rst_ready", 32'(bus.iomem_ready), 32'd0);
        chk("rst_rdata", bus.iomem_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Single edge request on irq_5: latency, status, EOI
        wr("en7", A_EN, 4'h1, 32'h7);
        irq_in = 3'b001;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 1) irq_in = 3'b000;
            chk($sformatf("lat_e%0d", k), 32'(cpu_irq), (k == 3) ? 32'h1 : 32'h0);
        end
        rd("st_active0", A_STAT, 32'h001);
        eoi_pulse(3'b001);
        rd("st_after_eoi", A_STAT, 32'h000);
        rd("pend_after_eoi", A_PEND, 32'h000);
        chk("no_redispatch", 32'(cpu_irq), 32'd0);

        // Simultaneous requests: priority order, non-active EOI ignored
        irq_in = 3'b111;
        tick();
        tick();
        irq_in = 3'b000;
        wait_dispatch(got, n);
        chk("prio_first", 32'(got), 32'h4);
        eoi_pulse(3'b011);
        rd("st_still_active2", A_STAT, 32'h004);
        eoi_pulse(3'b100);
        wait_dispatch(got, n);
        chk("prio_second", 32'(got), 32'h2);
        eoi_pulse(3'b010);
        wait_dispatch(got, n);
        chk("prio_third", 32'(got), 32'h1);
        eoi_pulse(3'b001);
        wait_dispatch(got, n);
        chk("prio_none_left", 32'(got), 32'h0);

        // Two rising edges on irq_6 before EOI -> overrun, then W1C
        sched = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000};
        for (int k = 0; k < 8; k++) begin
            irq_in = sched[k];
            tick();
            if (k == 3) chk("ovr_dispatch", 32'(cpu_irq), 32'h2);
        end
        rd("st_overrun", A_STAT, 32'h022);
        wr("clr_overrun", A_STAT, 4'h1, 32'h20);
        rd("st_ovr_clr", A_STAT, 32'h002);
        eoi_pulse(3'b010);
        rd("pend_ovr_done", A_PEND, 32'h000);

        // No EOI: timeout after 16 wait cycles, then redispatch of same source
        irq_in = 3'b001;
        tick();
        tick();
        irq_in = 3'b000;
        wait_dispatch(got, n);
        chk("tmo_first", 32'(got), 32'h1);
        chk("tmo_first_lat", 32'(n), 32'd2);
        wait_dispatch(got, n);
        chk("tmo_redispatch", 32'(got), 32'h1);
        chk("tmo_gap", 32'(n), 32'd17);
        rd("st_tmo", A_STAT, 32'h101);
        wr("clr_tmo", A_STAT, 4'h2, 32'h100);
        rd("st_tmo_clr", A_STAT, 32'h001);
        eoi_pulse(3'b001);
        rd("pend_tmo_done", A_PEND, 32'h000);

        // Level mode on irq_7
        wr("en0", A_EN, 4'h1, 32'h0);
        wr("mode3", A_MODE, 4'h1, 32'h3);
        irq_in = 3'b100;
        repeat (3) tick();
        rd("lvl_pend_hi", A_PEND, 32'h004);
        wr("lvl_w1c", A_PEND, 4'h1, 32'h4);
        rd("lvl_pend_w1c", A_PEND, 32'h004);
        irq_in = 3'b000;
        repeat (3) tick();
        rd("lvl_pend_lo", A_PEND, 32'h000);
        wr("mode7", A_MODE, 4'h1, 32'h7);
        wr("en7b", A_EN, 4'h1, 32'h7);

        // Reset in WAIT_EOI with bus/irq/eoi activity held during reset
        irq_in = 3'b100;
        tick();
        tick();
        irq_in = 3'b000;
        wait_dispatch(got, n);
        chk("rst_pre_dispatch", 32'(got), 32'h4);
        reset = 1'b1;
        irq_in = 3'b111;
        eoi = 3'b111;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = A_EN;
        bus.iomem_wstrb = 4'h1;
        bus.iomem_wdata = 32'h7;
        tick();
        chk("rst2_cpu_irq", 32'(cpu_irq), 32'd0);
        chk("rst2_ready", 32'(bus.iomem_ready), 32'd0);
        chk("rst2_rdata", bus.iomem_rdata, 32'd0);
        tick();
        chk("rst2_ready_hold", 32'(bus.iomem_ready), 32'd0);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        irq_in = 3'b000;
        eoi = 3'b000;
        reset = 1'b0;
        tick();
        rd("rst_en", A_EN, 32'h0);
        rd("rst_pend", A_PEND, 32'h0);
        rd("rst_mode", A_MODE, 32'h7);
        rd("rst_stat", A_STAT, 32'h0);
        bus_access(BASE + 32'h10, 4'h0, 32'd0, r_oob, ok_oob);
        chk("oob_no_ready", 32'(ok_oob), 32'd0);
        chk("oob_rdata", bus.iomem_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
